// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP) for the single-issue core.
// Ports:
//   clock, reset        core clock; asynchronous active-high reset
//   inst_type           decoded instruction class (INST_* encodings)
//   com_res             branch comparator result, 1 = taken
//   ifetch_ack/mem_ack  instruction / data memory handshake acks
//   ifetch_req, inst_we instruction fetch request and instruction-register latch
//   mem_req, mem_we     data memory request, 1 = store
//   reg_we, wb_sel      register-file write strobe; 0 ALU, 1 load data, 2 PC+4
//   pc_we, pc_sel       PC update; 0 PC+4, 1 PC+imm, 2 ALU result with bit 0 cleared
//   halt                core is trapped
// Optional: define CTRL_PERF_CNT_EN to add 64-bit cycle_cnt and instret_cnt outputs.
`ifndef INST_TYPE_END
`define INST_ILLEGAL  0
`define INST_IMM      1
`define INST_REG      2
`define INST_UPP      3
`define INST_AUIPC    4
`define INST_LOAD     5
`define INST_STORE    6
`define INST_BRANCH   7
`define INST_JUMP     8
`define INST_JUMPR    9
`define INST_SYSTEM   10
`define INST_TYPE_END 10
`endif
module ctrl_fsm #(
  parameter int ITYPE_W         = `INST_TYPE_END + 1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ITYPE_W-1:0] inst_type,
  input  logic               com_res,
  input  logic               ifetch_ack,
  input  logic               mem_ack,
  output logic               ifetch_req,
  output logic               inst_we,
  output logic               mem_req,
  output logic               mem_we,
  output logic               reg_we,
  output logic [1:0]         wb_sel,
  output logic               pc_we,
  output logic [1:0]         pc_sel,
  output logic               halt
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [63:0]        cycle_cnt,
  output logic [63:0]        instret_cnt
`endif
);
  localparam logic [ITYPE_W-1:0] T_IMM    = ITYPE_W'(`INST_IMM);
  localparam logic [ITYPE_W-1:0] T_REG    = ITYPE_W'(`INST_REG);
  localparam logic [ITYPE_W-1:0] T_UPP    = ITYPE_W'(`INST_UPP);
  localparam logic [ITYPE_W-1:0] T_AUIPC  = ITYPE_W'(`INST_AUIPC);
  localparam logic [ITYPE_W-1:0] T_LOAD   = ITYPE_W'(`INST_LOAD);
  localparam logic [ITYPE_W-1:0] T_STORE  = ITYPE_W'(`INST_STORE);
  localparam logic [ITYPE_W-1:0] T_BRANCH = ITYPE_W'(`INST_BRANCH);
  localparam logic [ITYPE_W-1:0] T_JUMP   = ITYPE_W'(`INST_JUMP);
  localparam logic [ITYPE_W-1:0] T_JUMPR  = ITYPE_W'(`INST_JUMPR);
  localparam logic [ITYPE_W-1:0] T_SYSTEM = ITYPE_W'(`INST_SYSTEM);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t             state_q, state_d;
  logic [ITYPE_W-1:0] itype_q, itype_d;

  // Class is captured in EXEC so MEM and WB see a stable value while waiting on acks.
  logic in_mem, in_ill;
  assign in_mem = (inst_type == T_LOAD) || (inst_type == T_STORE);
  // Any code that is not a known class (including 0) is treated as illegal.
  assign in_ill = !(inst_type inside {T_IMM, T_REG, T_UPP, T_AUIPC, T_LOAD, T_STORE,
                                      T_BRANCH, T_JUMP, T_JUMPR, T_SYSTEM});

  logic q_ld, q_st, q_br, q_j, q_jr, q_alu;
  assign q_ld  = itype_q == T_LOAD;
  assign q_st  = itype_q == T_STORE;
  assign q_br  = itype_q == T_BRANCH;
  assign q_j   = itype_q == T_JUMP;
  assign q_jr  = itype_q == T_JUMPR;
  assign q_alu = itype_q inside {T_IMM, T_REG, T_UPP, T_AUIPC, T_SYSTEM};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      itype_q <= '0;
    end else begin
      state_q <= state_d;
      itype_q <= itype_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    itype_d    = itype_q;
    ifetch_req = 1'b0;
    inst_we    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    wb_sel     = 2'd0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    halt       = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        ifetch_req = 1'b1;
        inst_we    = ifetch_ack;
        state_d    = ifetch_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        itype_d = inst_type;
        state_d = in_mem ? S_MEM : (in_ill && HALT_ON_ILLEGAL) ? S_TRAP : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = q_st;
        // A store has nothing to write back, so it retires here.
        pc_we   = mem_ack && q_st;
        state_d = !mem_ack ? S_MEM : q_st ? S_FETCH : S_WB;
      end
      S_WB: begin
        pc_we   = 1'b1;
        reg_we  = q_alu || q_ld || q_j || q_jr;
        wb_sel  = q_ld ? 2'd1 : (q_j || q_jr) ? 2'd2 : 2'd0;
        pc_sel  = q_jr ? 2'd2 : (q_j || (q_br && com_res)) ? 2'd1 : 2'd0;
        state_d = S_FETCH;
      end
      S_TRAP:   halt = 1'b1;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  logic [63:0] cycle_cnt_q, instret_cnt_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_q + 64'd1;
      instret_cnt_q <= instret_cnt_q + {63'd0, pc_we};
    end
  end
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed scoreboard bench for ctrl_fsm.
`ifndef INST_TYPE_END
`define INST_ILLEGAL  0
`define INST_IMM      1
`define INST_REG      2
`define INST_UPP      3
`define INST_AUIPC    4
`define INST_LOAD     5
`define INST_STORE    6
`define INST_BRANCH   7
`define INST_JUMP     8
`define INST_JUMPR    9
`define INST_SYSTEM   10
`define INST_TYPE_END 10
`endif
module tb_ctrl_fsm;
  localparam int W = `INST_TYPE_END + 1;
  localparam logic [W-1:0] T_ILL = W'(`INST_ILLEGAL);
  localparam logic [W-1:0] T_IMM = W'(`INST_IMM);
  localparam logic [W-1:0] T_REG = W'(`INST_REG);
  localparam logic [W-1:0] T_UPP = W'(`INST_UPP);
  localparam logic [W-1:0] T_AUIPC = W'(`INST_AUIPC);
  localparam logic [W-1:0] T_LOAD = W'(`INST_LOAD);
  localparam logic [W-1:0] T_STORE = W'(`INST_STORE);
  localparam logic [W-1:0] T_BRANCH = W'(`INST_BRANCH);
  localparam logic [W-1:0] T_JUMP = W'(`INST_JUMP);
  localparam logic [W-1:0] T_JUMPR = W'(`INST_JUMPR);
  localparam logic [W-1:0] T_SYSTEM = W'(`INST_SYSTEM);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] inst_type = '0;
  logic com_res = 1'b0, ifetch_ack = 1'b0, mem_ack = 1'b0;
  logic ifetch_req, inst_we, mem_req, mem_we, reg_we, pc_we, halt;
  logic [1:0] wb_sel, pc_sel;
  logic [W-1:0] inst_type2 = '0;
  logic ifetch_req2, inst_we2, mem_req2, mem_we2, reg_we2, pc_we2, halt2;
  logic [1:0] wb_sel2, pc_sel2;
`ifdef CTRL_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt, cycle_cnt2, instret_cnt2;
`endif

  always #5 clock = ~clock;

  ctrl_fsm #(.ITYPE_W(W), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clock(clock), .reset(reset), .inst_type(inst_type), .com_res(com_res),
    .ifetch_ack(ifetch_ack), .mem_ack(mem_ack), .ifetch_req(ifetch_req), .inst_we(inst_we),
    .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we),
    .pc_sel(pc_sel), .halt(halt)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  ctrl_fsm #(.ITYPE_W(W), .HALT_ON_ILLEGAL(1'b0)) dut_nop (
    .clock(clock), .reset(reset), .inst_type(inst_type2), .com_res(1'b0),
    .ifetch_ack(1'b1), .mem_ack(1'b1), .ifetch_req(ifetch_req2), .inst_we(inst_we2),
    .mem_req(mem_req2), .mem_we(mem_we2), .reg_we(reg_we2), .wb_sel(wb_sel2), .pc_we(pc_we2),
    .pc_sel(pc_sel2), .halt(halt2)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt2), .instret_cnt(instret_cnt2)
`endif
  );

  logic [10:0] obs, obs2;
  assign obs  = {ifetch_req, inst_we, mem_req, mem_we, reg_we, wb_sel, pc_we, pc_sel, halt};
  assign obs2 = {ifetch_req2, inst_we2, mem_req2, mem_we2, reg_we2, wb_sel2, pc_we2, pc_sel2, halt2};

  int checks = 0, passes = 0;
  string tag = "init";
  logic [10:0] exp_q[$];
  logic [10:0] exp2_q[$];

  function automatic logic [10:0] ov(input logic ifr, iw, mr, mw, rw, input logic [1:0] wbs,
                                      input logic pw, input logic [1:0] ps, input logic h);
    return {ifr, iw, mr, mw, rw, wbs, pw, ps, h};
  endfunction

  localparam logic [10:0] Z = 11'd0;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", t, got, want);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) chk(tag, {53'd0, obs}, {53'd0, exp_q.pop_front()});
    if (exp2_q.size() > 0) chk("nop_dut", {53'd0, obs2}, {53'd0, exp2_q.pop_front()});
  end

  task automatic step(input string t, input logic [W-1:0] ity, input logic cr, ia, ma,
                      input logic [10:0] e);
    tag = t;
    inst_type = ity;
    com_res = cr;
    ifetch_ack = ia;
    mem_ack = ma;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Drives one instruction starting in FETCH; acks of the other handshake are held
  // high where they must be ignored.
  task automatic instr(input string t, input logic [W-1:0] ity, input logic cr,
                       input int fw, input int mw);
    logic ld, st, ill, rw;
    logic [1:0] wbs, ps;
    ld  = ity == T_LOAD;
    st  = ity == T_STORE;
    ill = ity == T_ILL;
    rw  = ity inside {T_IMM, T_REG, T_UPP, T_AUIPC, T_SYSTEM, T_LOAD, T_JUMP, T_JUMPR};
    wbs = ld ? 2'd1 : (ity == T_JUMP || ity == T_JUMPR) ? 2'd2 : 2'd0;
    ps  = (ity == T_JUMPR) ? 2'd2 : (ity == T_JUMP || (ity == T_BRANCH && cr)) ? 2'd1 : 2'd0;
    for (int i = 0; i < fw; i++) step({t, ":fwait"}, ity, cr, 1'b0, 1'b1, ov(1,0,0,0,0,0,0,0,0));
    step({t, ":fetch"}, ity, cr, 1'b1, 1'b0, ov(1,1,0,0,0,0,0,0,0));
    step({t, ":decode"}, ity, cr, 1'b1, 1'b1, Z);
    step({t, ":exec"}, ity, cr, 1'b1, 1'b1, Z);
    if (ld || st) begin
      for (int i = 0; i < mw; i++) step({t, ":mwait"}, ity, cr, 1'b1, 1'b0, ov(0,0,1,st,0,0,0,0,0));
      step({t, ":mack"}, ity, cr, 1'b1, 1'b1, ov(0,0,1,st,0,0,st,0,0));
    end
    if (!st && !ill) step({t, ":wb"}, ity, cr, 1'b1, 1'b1, ov(0,0,0,0,rw,wbs,1,ps,0));
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", {53'd0, obs}, 64'd0);
    reset = 1'b0;
    step("idle", T_IMM, 1'b0, 1'b1, 1'b1, Z);
    instr("addi", T_IMM, 1'b0, 0, 0);
    instr("lw", T_LOAD, 1'b0, 0, 3);
    instr("sw", T_STORE, 1'b0, 0, 0);
    instr("beq_t", T_BRANCH, 1'b1, 0, 0);
    instr("beq_nt", T_BRANCH, 1'b0, 0, 0);
    instr("jalr", T_JUMPR, 1'b0, 0, 0);
    instr("jal", T_JUMP, 1'b0, 1, 0);
    instr("add", T_REG, 1'b0, 2, 0);
    instr("lui", T_UPP, 1'b0, 0, 0);
    instr("auipc", T_AUIPC, 1'b0, 0, 0);
    instr("sys", T_SYSTEM, 1'b0, 0, 0);
    instr("sw_wait", T_STORE, 1'b0, 0, 2);
    // Reset while the fetch request waits, with an ack arriving alongside it.
    tag = "rst_mid:fwait";
    ifetch_ack = 1'b0;
    mem_ack = 1'b0;
    exp_q.push_back(ov(1,0,0,0,0,0,0,0,0));
    @(negedge clock);
    #1;
    reset = 1'b1;
    ifetch_ack = 1'b1;
    #1;
    chk("rst_mid:async", {53'd0, obs}, 64'd0);
    @(posedge clock);
    #1;
    chk("rst_mid:held", {53'd0, obs}, 64'd0);
    reset = 1'b0;
    step("rst_mid:idle_ack", T_IMM, 1'b0, 1'b1, 1'b1, Z);
    instr("post_rst", T_IMM, 1'b0, 0, 0);
    // Illegal instruction traps and stays trapped.
    instr("ill", T_ILL, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) step("trap", T_ILL, 1'b0, 1'b1, 1'b1, ov(0,0,0,0,0,0,0,0,1));
    reset = 1'b1;
    #1;
    chk("trap:reset", {53'd0, obs}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    // Both instances restart in lockstep; the NOP instance retires each illegal word with PC+4.
    exp2_q.push_back(Z);
    for (int i = 0; i < 3; i++) begin
      exp2_q.push_back(ov(1,1,0,0,0,0,0,0,0));
      exp2_q.push_back(Z);
      exp2_q.push_back(Z);
      exp2_q.push_back(ov(0,0,0,0,0,0,1,0,0));
    end
    step("idle2", T_IMM, 1'b0, 1'b1, 1'b1, Z);
    for (int i = 0; i < 3; i++) instr("addi_n", T_IMM, 1'b0, 0, 0);
`ifdef CTRL_PERF_CNT_EN
    chk("instret_cnt", instret_cnt, 64'd3);
    chk("cycle_cnt", cycle_cnt, 64'd13);
`endif
    chk("queues_drained", 64'(exp_q.size() + exp2_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
- Multi-cycle control sequencer for the single-issue core.
- Walks each instruction through FETCH, DECODE, EXEC, optional MEM, and WB.
- Drives instruction-fetch and data-memory req/ack handshakes, the instruction latch, the PC mux, and register-file write enable.
- Classifies instructions from the decoder's inst_type and the comparator's branch result, using the shared INST_* encodings in defs.vh.

Parameters:
- ITYPE_W, default INST_TYPE_END+1: width of the inst_type input.
- HALT_ON_ILLEGAL, default 1: 1 means an illegal inst_type enters TRAP; 0 means it is treated as a NOP (PC+4, no write).

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- inst_type  in  ITYPE_W  decoded instruction class from the decoder
- com_res  in  1  branch comparator result, 1 = taken
- ifetch_ack  in  1  instruction memory has returned data this cycle
- mem_ack  in  1  data memory access complete this cycle
- ifetch_req  out  1  instruction fetch request
- inst_we  out  1  latch the fetched word into the instruction register
- mem_req  out  1  data memory request
- mem_we  out  1  1 = store, 0 = load; valid while mem_req = 1
- reg_we  out  1  register-file write strobe
- wb_sel  out  2  0 = ALU result, 1 = load data, 2 = PC+4
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit 0 cleared
- halt  out  1  core is trapped

Behaviour:
- State register
  - States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - Reset is asynchronous: state goes to IDLE and every output is 0 immediately. Outputs remain 0 while reset is held.
- Outputs are Moore, decoded from the state (plus the inputs noted per state).
  - Any strobe not listed for a state is 0.
- IDLE
  - Exactly one cycle after reset release, then go to FETCH.
  - ifetch_ack and mem_ack are ignored here.
- FETCH
  - ifetch_req = 1 for every cycle in this state.
  - On ifetch_ack = 1: inst_we = 1 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH with the request held.
  - ifetch_req never drops before ack.
- DECODE
  - One cycle, so decoder outputs and register reads settle. Then go to EXEC.
- EXEC (one cycle); next state by class:
  - LOAD or STORE: go to MEM.
  - Illegal (inst_type == 0): go to TRAP if HALT_ON_ILLEGAL, else go to WB.
  - All other classes: go to WB.
- MEM
  - mem_req = 1, with mem_we = 1 for STORE and 0 for LOAD.
  - Request and mem_we are held stable until mem_ack.
  - On mem_ack with LOAD: go to WB.
  - On mem_ack with STORE: pc_we = 1 and pc_sel = 0 in that same cycle, then go to FETCH.
- WB (one cycle)
  - pc_we = 1, then go to FETCH.
  - IMM, REG, UPP, AUIPC, SYSTEM: reg_we = 1, wb_sel = 0, pc_sel = 0.
  - LOAD: reg_we = 1, wb_sel = 1, pc_sel = 0.
  - JUMP: reg_we = 1, wb_sel = 2, pc_sel = 1.
  - JUMPR: reg_we = 1, wb_sel = 2, pc_sel = 2.
  - BRANCH: reg_we = 0; pc_sel = 1 if com_res else 0.
  - Illegal as NOP: reg_we = 0, pc_sel = 0.
  - x0 writes are suppressed by the register file, not by this block.
- TRAP
  - halt = 1; no requests issued. Only reset leaves TRAP.
- Latency, with ack arriving in the same cycle as the request:
  - ALU, jump, branch: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each ack-wait cycle adds 1.
- Boundary conditions
  - Reset asserted mid-handshake: requests drop asynchronously. A late ack after reset is ignored.
  - ifetch_ack outside FETCH and mem_ack outside MEM are ignored.
  - Ack and reset in the same cycle: reset wins, and no inst_we or pc_we is recorded.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- When defined, the block adds two ports:
  - cycle_cnt  out  64: increments every cycle out of reset, including TRAP.
  - instret_cnt  out  64: increments on every cycle with pc_we = 1.
  - Both counters reset to 0 and wrap modulo 2^64.
- When not defined, these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- ADDI, acks tied high, from reset release → inst_we in cycle 2 (IDLE = cycle 1), reg_we = 1 with wb_sel = 0 and pc_we = 1 in cycle 5, next ifetch_req in cycle 6.
- LW with mem_ack delayed 3 cycles → mem_req high for 4 cycles with mem_we = 0, then WB with wb_sel = 1; 8 cycles total.
- SW, mem_ack immediate → mem_we = 1, pc_we = 1 in the MEM cycle, reg_we never asserted.
- BEQ with com_res = 1, then with com_res = 0 → pc_sel = 1, then pc_sel = 0; reg_we = 0 both times. JALR → pc_sel = 2, wb_sel = 2.
- inst_type = 0 with HALT_ON_ILLEGAL = 1 → halt = 1 from the cycle after EXEC and held for 20 cycles with no requests; reset clears it. With HALT_ON_ILLEGAL = 0 → a single pc_we with pc_sel = 0.
- Reset asserted while ifetch_req is waiting, ifetch_ack pulsed during IDLE → outputs 0 immediately, no inst_we, fetch restarts cleanly. With CTRL_PERF_CNT_EN: instret_cnt = 3 after 3 ADDIs.
